// File: rtl/md_pkg.sv
// Shared op encodings and FSM state type for the multiply/divide unit.
// Operation codes follow the MIPS HI/LO instruction set.
package md_pkg;

    localparam int MD_OPW = 3;

    localparam logic [MD_OPW-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OPW-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OPW-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OPW-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OPW-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OPW-1:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Applies result signs to unsigned magnitudes: product/quotient negated when operand signs
// differ, remainder follows the dividend. Purely combinational, no backpressure.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mag_hi,
    input  logic [WIDTH-1:0] mag_lo,
    input  logic             is_mul,
    input  logic             neg_res,
    input  logic             neg_rem,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign prod     = {mag_hi, mag_lo};
    assign prod_neg = -prod;

    always_comb begin
        res_hi = mag_hi;
        res_lo = mag_lo;
        if (is_mul) begin
            if (neg_res) begin
                {res_hi, res_lo} = prod_neg;
            end
        end else begin
            if (neg_res) begin
                res_lo = -mag_lo;
            end
            if (neg_rem) begin
                res_hi = -mag_hi;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide with HI/LO registers; mult/div done WIDTH+2 cycles after accept,
// MTHI/MTLO and divide-by-zero done next cycle. start while busy is dropped, flush cancels.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = MD_OPW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state, state_nxt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    count;
    logic             is_mul, neg_res, neg_rem;

    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic op_signed, op_muldiv, b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_mult   = (op == OPW'(MD_MULT));
    assign op_multu  = (op == OPW'(MD_MULTU));
    assign op_div    = (op == OPW'(MD_DIV));
    assign op_divu   = (op == OPW'(MD_DIVU));
    assign op_mthi   = (op == OPW'(MD_MTHI));
    assign op_mtlo   = (op == OPW'(MD_MTLO));
    assign op_signed = op_mult | op_div;
    assign op_muldiv = op_mult | op_multu | op_div | op_divu;
    assign b_zero    = (b == '0);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One iteration step for each algorithm; rem holds the upper half (mult) or partial remainder (div).
    logic [WIDTH:0] mul_sum, div_shift;
    logic           div_ge;

    assign mul_sum   = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : '0);
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, dvs});

    logic [WIDTH-1:0] fix_hi, fix_lo;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .mag_hi  (rem),
        .mag_lo  (quo),
        .is_mul  (is_mul),
        .neg_res (neg_res),
        .neg_rem (neg_rem),
        .res_hi  (fix_hi),
        .res_lo  (fix_lo)
    );

    logic             launch, write_hi, write_lo, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        done_nxt  = 1'b0;
        dbz_nxt   = 1'b0;
        write_hi  = 1'b0;
        write_lo  = 1'b0;
        hi_nxt    = fix_hi;
        lo_nxt    = fix_lo;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op_mthi) begin
                        write_hi = 1'b1;
                        hi_nxt   = a;
                        done_nxt = 1'b1;
                    end else if (op_mtlo) begin
                        write_lo = 1'b1;
                        lo_nxt   = a;
                        done_nxt = 1'b1;
                    end else if ((op_div | op_divu) && b_zero) begin
                        done_nxt = 1'b1;
                        dbz_nxt  = 1'b1;
                    end else if (op_muldiv) begin
                        launch    = 1'b1;
                        state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (count == LAST) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
                write_hi  = 1'b1;
                write_lo  = 1'b1;
                done_nxt  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Flush wins over everything except reset, including a same-cycle start.
        if (flush) begin
            state_nxt = ST_IDLE;
            launch    = 1'b0;
            done_nxt  = 1'b0;
            dbz_nxt   = 1'b0;
            write_hi  = 1'b0;
            write_lo  = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            if (write_hi) begin
                hi <= hi_nxt;
            end
            if (write_lo) begin
                lo <= lo_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            count   <= '0;
            is_mul  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (launch) begin
            rem     <= '0;
            count   <= '0;
            is_mul  <= op_mult | op_multu;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (op_mult | op_multu) begin
                quo <= b_mag;
                dvs <= a_mag;
            end else begin
                quo <= a_mag;
                dvs <= b_mag;
            end
        end else if (state == ST_CALC) begin
            count <= count + 1'b1;
            if (is_mul) begin
                rem <= mul_sum[WIDTH:1];
                quo <= {mul_sum[0], quo[WIDTH-1:1]};
            end else begin
                rem <= div_ge ? WIDTH'(div_shift - {1'b0, dvs}) : div_shift[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], div_ge};
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic              clk = 1'b0;
    logic              reset_n, start, flush;
    logic [MD_OPW-1:0] op;
    logic [W-1:0]      a, b;
    logic              busy, done, div_by_zero;
    logic [W-1:0]      hi, lo;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] ref_hi  = '0;
    logic [W-1:0] ref_lo  = '0;

    mult_div_unit #(.WIDTH(W), .OPW(MD_OPW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one op given the current HI/LO contents.
    task automatic model(input logic [MD_OPW-1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] eh, output logic [W-1:0] el,
                         output logic edz, output bit arith);
        longint      sa, sb;
        logic [63:0] p;
        eh    = ref_hi;
        el    = ref_lo;
        edz   = 1'b0;
        arith = 1'b0;
        sa    = longint'($signed(ma));
        sb    = longint'($signed(mb));
        case (mop)
            MD_MULT:  begin p = 64'(sa * sb); {eh, el} = p; arith = 1'b1; end
            MD_MULTU: begin p = {32'b0, ma} * {32'b0, mb}; {eh, el} = p; arith = 1'b1; end
            MD_DIV:   if (mb == 0) edz = 1'b1;
                      else begin el = W'(sa / sb); eh = W'(sa % sb); arith = 1'b1; end
            MD_DIVU:  if (mb == 0) edz = 1'b1;
                      else begin el = ma / mb; eh = ma % mb; arith = 1'b1; end
            MD_MTHI:  eh = ma;
            MD_MTLO:  el = ma;
            default:  ;
        endcase
    endtask

    // Issues in the current cycle; returns in the cycle done is observed (or after a bounded wait).
    task automatic run_op(input string tag, input logic [MD_OPW-1:0] mop,
                          input logic [W-1:0] ma, input logic [W-1:0] mb);
        logic [W-1:0] eh, el;
        logic         edz;
        bit           arith;
        int           k, busy_cnt, hold_bad;
        model(mop, ma, mb, eh, el, edz, arith);
        start = 1'b1; op = mop; a = ma; b = mb;
        tick();
        start = 1'b0; op = MD_OPW'($urandom); a = $urandom; b = $urandom;
        k = 1; busy_cnt = 0; hold_bad = 0;
        while (!done && k < W + 8) begin
            if (busy) busy_cnt++;
            if (hi !== ref_hi || lo !== ref_lo) hold_bad++;
            tick();
            k++;
        end
        check({tag, "/done_cycle"}, k, arith ? W + 2 : 1);
        check({tag, "/busy_cycles"}, busy_cnt, arith ? W + 1 : 0);
        check({tag, "/busy_at_done"}, busy, 1'b0);
        check({tag, "/hold"}, hold_bad, 0);
        check({tag, "/dbz"}, div_by_zero, edz);
        check({tag, "/hi"}, hi, eh);
        check({tag, "/lo"}, lo, el);
        ref_hi = eh;
        ref_lo = el;
    endtask

    initial begin
        logic [MD_OPW-1:0] r_op;
        logic [W-1:0]      ra, rb;
        int                seen;

        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) tick();
        check("rst/busy", busy, 1'b0);
        check("rst/done", done, 1'b0);
        check("rst/dbz", div_by_zero, 1'b0);
        check("rst/hi", hi, 32'h0);
        check("rst/lo", lo, 32'h0);
        reset_n = 1'b1;
        tick();

        run_op("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD);
        tick();
        check("done_single_pulse", done, 1'b0);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_b2b", MD_DIVU, 32'hFFFF_FFFF, 32'd10);
        run_op("divu_by0", MD_DIVU, 32'd100, 32'd0);
        run_op("div_by0", MD_DIV, 32'h8000_0000, 32'd0);
        run_op("div_minneg", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_minneg", MD_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op("mtlo", MD_MTLO, 32'hA5A5_0F0F, 32'd0);
        run_op("div_neg_rem", MD_DIV, 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 40; i++) begin
            r_op = MD_OPW'($urandom_range(0, 5));
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 5) == 0) rb = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rnd%0d", i), r_op, ra, rb);
        end

        // Flush mid-CALC with a same-cycle MTHI start that must be dropped.
        start = 1'b1; op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        seen = 0;
        for (int k = 1; k < 10; k++) begin
            if (done) seen++;
            tick();
        end
        check("flush/busy_before", busy, 1'b1);
        flush = 1'b1; start = 1'b1; op = MD_MTHI; a = $urandom; b = '0;
        tick();
        flush = 1'b0; start = 1'b0;
        check("flush/busy_after", busy, 1'b0);
        check("flush/done", done, 1'b0);
        check("flush/done_seen", seen, 0);
        check("flush/hi", hi, ref_hi);
        check("flush/lo", lo, ref_lo);
        run_op("after_flush", MD_MULT, 32'h1234_5678, 32'hFEDC_BA98);

        // Starts while busy are ignored, then reset aborts the running op.
        run_op("mthi_1234", MD_MTHI, 32'd1234, 32'd0);
        start = 1'b1; op = MD_MULT; a = $urandom; b = $urandom;
        tick();
        seen = 0;
        for (int k = 1; k < 15; k++) begin
            start = 1'b1;
            op    = (k % 2 == 0) ? MD_MULT : MD_MTLO;
            a     = $urandom;
            b     = $urandom;
            if (done) seen++;
            tick();
        end
        start = 1'b0;
        check("ignore/busy", busy, 1'b1);
        check("ignore/done_seen", seen, 0);
        check("ignore/hi", hi, ref_hi);
        check("ignore/lo", lo, ref_lo);
        reset_n = 1'b0;
        tick();
        check("midrst/busy", busy, 1'b0);
        check("midrst/done", done, 1'b0);
        check("midrst/hi", hi, 32'h0);
        check("midrst/lo", lo, 32'h0);
        reset_n = 1'b1;
        ref_hi  = '0;
        ref_lo  = '0;
        seen    = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) seen++;
            tick();
        end
        check("midrst/no_done", seen, 0);
        run_op("post_rst_div", MD_DIV, 32'hFFFF_FF9C, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
